// File: rtl/rvj1_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : rvj1_dmem_resp
// Purpose  : Data-memory responder for the rvj1 core. Accepts one word-aligned
//            request at a time over a req/gnt/rvalid handshake, performs
//            byte-lane writes or full-word reads on an internal word array and
//            inserts WAIT_STATES wait cycles before the one-cycle response.
// Ports    : clk_i, rst_i (async, active-high)
//            data_req_i/we_i/be_i/addr_i/wdata_i : request from the LSU
//            data_gnt_o    : request accepted this cycle (combinational)
//            data_rvalid_o : one-cycle response pulse (registered)
//            data_rdata_o  : read word, valid with rvalid (registered)
//            data_err_o    : bus error, qualified by rvalid (registered)
// Config   : `RVJ1_DMEM_ERR_EN - when defined, addresses outside the array
//            window respond with data_err_o=1 and never write the array;
//            when undefined, addresses alias modulo the array size.
// Revision : 1.0 - initial release
// ============================================================================
module rvj1_dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int c_AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [3:0]        r_be;
    logic [c_AW-1:0]   r_idx;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic              r_err_out;

    // Array is deliberately left without reset.
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_gnt;
    logic [31:0]       w_off;
    logic [c_AW-1:0]   w_in_idx;
    logic              w_in_err;
    logic              w_from_in;
    logic              w_op_we;
    logic [3:0]        w_op_be;
    logic [c_AW-1:0]   w_op_idx;
    logic [31:0]       w_op_wdata;
    logic              w_op_err;
    logic              w_enter_resp;
    logic              w_mem_we;

    // Grant is held off while reset is asserted so a request present during
    // reset is first accepted in the cycle after release.
    assign w_gnt = data_req_i && (r_state == ST_IDLE) && !rst_i;

    // BASE_ADDR is aligned to the array span, so the offset's index bits are
    // exactly the word index and everything above them is the window check.
    assign w_off    = data_addr_i - BASE_ADDR;
    assign w_in_idx = w_off[c_AW+1:2];

`ifdef RVJ1_DMEM_ERR_EN
    assign w_in_err = (w_off >> (c_AW + 2)) != 32'd0;
`else
    assign w_in_err = 1'b0;
`endif

    // With zero wait states RESP is entered on the grant edge itself, so the
    // array operation must use the live request fields instead of the
    // captured copies.
    assign w_from_in  = (r_state == ST_IDLE);
    assign w_op_we    = w_from_in ? data_we_i    : r_we;
    assign w_op_be    = w_from_in ? data_be_i    : r_be;
    assign w_op_idx   = w_from_in ? w_in_idx     : r_idx;
    assign w_op_wdata = w_from_in ? data_wdata_i : r_wdata;
    assign w_op_err   = w_from_in ? w_in_err     : r_err;

    assign w_enter_resp = (w_gnt && (WAIT_STATES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd1));
    assign w_mem_we     = w_enter_resp && w_op_we && !w_op_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_be      <= 4'd0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            r_err     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_err_out <= 1'b0;
        end else begin
            // RESP is entered exactly once per transaction and lasts one
            // cycle, so rvalid simply mirrors the entry condition.
            r_rvalid <= w_enter_resp;

            if (w_enter_resp) begin
                r_rdata   <= (!w_op_we && !w_op_err) ? r_mem[w_op_idx] : 32'd0;
                r_err_out <= w_op_err;
            end else if (r_state == ST_RESP) begin
                r_rdata   <= 32'd0;
                r_err_out <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_we    <= data_we_i;
                        r_be    <= data_be_i;
                        r_idx   <= w_in_idx;
                        r_wdata <= data_wdata_i;
                        r_err   <= w_in_err;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write on the RESP-entry edge. Reset forces the FSM to IDLE
    // asynchronously, so a write still waiting in WAIT is never committed.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (w_op_be[n]) begin
                    r_mem[w_op_idx][8*n +: 8] <= w_op_wdata[8*n +: 8];
                end
            end
        end
    end

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err_out;

endmodule
`default_nettype wire

// File: tb/tb_rvj1_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvj1_dmem_resp
// Purpose  : Self-checking bench for rvj1_dmem_resp. Instance 0 uses one wait
//            state, instance 1 uses zero. A word-array reference model in the
//            bench predicts read data, error flags and response latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvj1_dmem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req    [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    logic [31:0] mdl [2][DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rvj1_dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[0]), .data_we_i(we[0]), .data_be_i(be[0]),
        .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
        .data_rdata_o(rdata[0]), .data_err_o(err[0])
    );

    rvj1_dmem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req[1]), .data_we_i(we[1]), .data_be_i(be[1]),
        .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
        .data_rdata_o(rdata[1]), .data_err_o(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // One transaction: lat = cycles from the grant cycle to the rvalid cycle,
    // or -1 if the grant or the response never arrives within the bound.
    task automatic txn(input int d, input logic we_v, input logic [3:0] be_v,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        @(negedge clk);
        req[d] = 1'b1; we[d] = we_v; be[d] = be_v; addr[d] = a; wdata[d] = wd;
        #1;
        n = 0;
        while (gnt[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (gnt[d] !== 1'b1) begin
            req[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rvalid[d] === 1'b1) begin
                lat = i;
                rd  = rdata[d];
                er  = err[d];
                break;
            end
        end
    endtask

    // Run a transaction and compare against the word-array model.
    task automatic txck(input int d, input logic we_v, input logic [3:0] be_v,
                        input logic [31:0] a, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd_o);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          i;
        logic        exp_err;
        logic [31:0] exp_rd;
`ifdef RVJ1_DMEM_ERR_EN
        exp_err = !((a >= BASE) && (a < BASE + 32'(4 * DEPTH)));
`else
        exp_err = 1'b0;
`endif
        i      = int'(((a - BASE) / 32'd4) % 32'(DEPTH));
        exp_rd = (!we_v && !exp_err) ? mdl[d][i] : 32'h0;
        txn(d, we_v, be_v, a, wd, rd, er, lat);
        check({tag, "_lat"},   32'(lat),    32'(1 + ws(d)));
        check({tag, "_err"},   {31'd0, er}, {31'd0, exp_err});
        check({tag, "_rdata"}, rd,          exp_rd);
        if (we_v && !exp_err) begin
            for (int n = 0; n < 4; n++) begin
                if (be_v[n]) mdl[d][i][8*n +: 8] = wd[8*n +: 8];
            end
        end
        rd_o = rd;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          idx;

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; addr[d] = BASE; wdata[d] = 32'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt",    {31'd0, gnt[0]},    32'd0);
        check("rst_rvalid", {31'd0, rvalid[0]}, 32'd0);
        check("rst_rdata",  rdata[0],           32'd0);
        check("rst_err",    {31'd0, err[0]},    32'd0);
        rst = 1'b0;

        // Initialise a pool of 16 words
        for (int k = 0; k < 16; k++) begin
            txck(0, 1'b1, 4'hF, BASE + 32'(k * 4), $urandom, "init", rd);
        end

        // Full-word write and read-back
        txck(0, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, "wr_full", rd);
        txck(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0, "rd_full", rd);
        check("rd_full_const", rd, 32'hDEAD_BEEF);

        // Single byte lane write
        txck(0, 1'b1, 4'b0100, 32'h8000_0010, 32'h00AA_0000, "wr_byte", rd);
        txck(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0, "rd_byte", rd);
        check("rd_byte_const", rd, 32'hDEAA_BEEF);

        // Write with no lanes enabled
        txck(0, 1'b1, 4'b0000, 32'h8000_0010, 32'h1234_5678, "wr_be0", rd);
        txck(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0, "rd_be0", rd);

        // Window edges: error responses or aliasing
`ifdef RVJ1_DMEM_ERR_EN
        txck(0, 1'b0, 4'hF, 32'h7FFF_FFFC, 32'h0, "oor_rd", rd);
        txck(0, 1'b1, 4'hF, 32'h8000_1000, 32'h5555_5555, "oor_wr", rd);
        txck(0, 1'b0, 4'hF, 32'h8000_0000, 32'h0, "oor_w0", rd);
`else
        txck(0, 1'b1, 4'hF, 32'h8000_1000, 32'h1122_3344, "alias_wr", rd);
        txck(0, 1'b0, 4'hF, 32'h8000_0000, 32'h0, "alias_rd", rd);
        check("alias_const", rd, 32'h1122_3344);
`endif

        // Reset during the wait state of a write
        txck(0, 1'b1, 4'hF, 32'h8000_0020, 32'h0, "rm_pre", rd);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h8000_0020; wdata[0] = 32'hCAFE_F00D;
        #1;
        check("rm_gnt", {31'd0, gnt[0]}, 32'd1);
        @(posedge clk);
        #1;
        we[0] = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rm_rvalid",   {31'd0, rvalid[0]}, 32'd0);
            check("rm_gnt_held", {31'd0, gnt[0]},    32'd0);
        end
        req[0] = 1'b0;
        rst = 1'b0;
        txck(0, 1'b0, 4'hF, 32'h8000_0020, 32'h0, "rm_rd", rd);
        check("rm_rd_const", rd, 32'h0);

        // Zero wait states: write/read, then continuous request throughput
        txck(1, 1'b1, 4'hF, BASE, 32'hA5A5_0F0F, "ws0_wr", rd);
        txck(1, 1'b0, 4'hF, BASE, 32'h0, "ws0_rd", rd);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = BASE;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("tp_gnt",    {31'd0, gnt[1]},    32'((k % 2) == 0));
            check("tp_rvalid", {31'd0, rvalid[1]}, 32'((k % 2) == 1));
        end
        req[1] = 1'b0;

        // Randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            idx = int'($urandom_range(0, 15));
            a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
`ifdef RVJ1_DMEM_ERR_EN
                if ($urandom_range(0, 1) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
                else                           a = a + 32'h1000;
`else
                a = a + 32'h1000 * 32'($urandom_range(1, 3));
`endif
            end
            txck(0, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, "rand", rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvj1_dmem_resp.md
# rvj1_dmem_resp

Data-memory responder for the rvj1 core: the memory-side end of the load-store unit's data bus. It accepts one word-aligned request at a time over a req/gnt/rvalid handshake, applies byte-lane writes or returns full-word reads from an internal word array, and inserts a programmable number of wait states. Out-of-range accesses are reported as bus errors, which the core maps to load/store access faults. It sits between the LSU and the SoC interconnect, or stands alone as tightly-coupled data RAM.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words in the array. Must be a power of two, ≥ 2.
- `WAIT_STATES`, default 1: cycles inserted between the grant and the response. Legal range 0..15.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0. Must be aligned to 4·DEPTH_WORDS.
- `clk_i` input, 1 bit: clock. One clock, rising edge.
- `rst_i` input, 1 bit: reset. Asynchronous and active-high.
- `data_req_i` input, 1 bit: request. The initiator holds it, with all request fields stable, until the grant.
- `data_we_i` input, 1 bit: 1 = write, 0 = read.
- `data_be_i` input, 4 bits: byte enables; bit n enables lane n (bits 8n+7:8n).
- `data_addr_i` input, 32 bits: byte address. Bits [1:0] are ignored.
- `data_wdata_i` input, 32 bits: write data, already lane-aligned by the LSU.
- `data_gnt_o` output, 1 bit: request accepted this cycle.
- `data_rvalid_o` output, 1 bit: one-cycle response pulse, for both reads and writes.
- `data_rdata_o` output, 32 bits: read word. Valid only while `data_rvalid_o` is high.
- `data_err_o` output, 1 bit: bus error. Qualified by `data_rvalid_o`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `data_gnt_o = data_req_i && state==IDLE`. This path is combinational.
- Grant edge: the FSM captures we/be/addr/wdata into registers and loads the wait counter with WAIT_STATES.
- Next state after the grant edge: WAIT when WAIT_STATES > 0, otherwise RESP directly.
- WAIT: the counter decrements every cycle. The FSM moves to RESP on the edge where the counter reaches 1.
- Array operation happens on the edge entering RESP:
  - Read: the word at the captured index is registered into `data_rdata_o`.
  - Write: each lane with be[n]=1 is updated; other lanes keep their contents; `data_rdata_o` = 0.
  - be = 4'b0000 on a write changes nothing but still produces a normal response.
- RESP: lasts exactly one cycle with `data_rvalid_o`=1, then returns to IDLE.
- No grant is issued in WAIT or RESP. Only one transaction is ever outstanding.
- Index is computed as `(addr − BASE_ADDR) >> 2`, using the low log2(DEPTH_WORDS) bits.
- A read of an address in the cycle after its write response returns the new data.
- The array itself is not reset. Contents after power-up are undefined (X in simulation).

## Timing
- Reset values: `data_gnt_o`=0 (state is IDLE), `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, counter=0.
- Latency: a grant in cycle T gives `data_rvalid_o` in cycle T+1+WAIT_STATES.
- Throughput: at most one transaction per WAIT_STATES+2 cycles. The earliest next grant is the cycle after RESP.
- Reset asserted mid-transaction:
  - The FSM goes to IDLE immediately and `data_rvalid_o` drops asynchronously.
  - The pending response is lost.
  - A pending write is not committed if reset arrives before the RESP-entry edge.
- A request present during reset is not granted until the first cycle after `rst_i` deasserts.
- `data_rvalid_o`, `data_rdata_o` and `data_err_o` are driven from registers, with no combinational input-to-output path. `data_gnt_o` is the one exception (see Operation).

## Configuration
- Macro: `RVJ1_DMEM_ERR_EN`.
- Defined:
  - An address outside [BASE_ADDR, BASE_ADDR+4·DEPTH_WORDS) is flagged at the grant edge.
  - In RESP it gives `data_err_o`=1 with `data_rvalid_o`=1 and `data_rdata_o`=0.
  - The array is not written. Latency is unchanged.
- Undefined:
  - `data_err_o` is tied to 0.
  - All addresses alias modulo the array size via the index bits; bits above them are ignored.

## Test plan
- Reset, then write 0xDEADBEEF with be=4'hF to 0x8000_0010, then read 0x8000_0010 (WAIT_STATES=1) → gnt in cycle T, rvalid at T+2, rdata=0xDEADBEEF, err=0.
- Byte write: be=4'b0100, wdata=0x00AA0000 to 0x8000_0010 → subsequent read returns 0xDEAABEEF.
- WAIT_STATES=0, req held high continuously → grant every 2nd cycle, rvalid one cycle after each grant, never two transactions outstanding.
- With RVJ1_DMEM_ERR_EN, read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH_WORDS=1024):
  - Both give rvalid with err=1 and rdata=0.
  - Word 0 is unchanged afterwards.
- Without RVJ1_DMEM_ERR_EN, write 0x11223344 to 0x8000_1000 → read of 0x8000_0000 returns 0x11223344, err=0.
- Assert rst_i in the WAIT cycle of a write of 0xCAFEF00D to 0x8000_0020 (prior contents 0x0) → rvalid never pulses; a read after reset returns 0x0.
